line_window_reader: RTL and testbench

Reader side of the edge-detection line buffering: accepts a raster pixel stream, keeps the two previous image lines in internal circular line memories, and assembles a registered 3x3 neighbourhood window for the Sobel/gradient stage. Sits between the pixel source and the gradient kernels, replacing ad-hoc tap-picking off shift delay lines with explicit row/column tracking and a valid qualifier.

---
 rtl/line_window_reader.sv | 105 ++++++++++
 tb/tb_line_window_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/line_window_reader.sv
// Raster pixel stream to registered 3x3 neighbourhood window, using two circular
// line memories (previous line and two lines back) plus explicit row/column tracking.
module line_window_reader #(
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 640
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [15:0]  pixel_in,
    input  logic                pixel_valid,
    output logic [143:0]        window,
    output logic                window_valid,
    output logic [15:0]         center_row,
    output logic [15:0]         center_col,
    output logic                frame_end
);

    localparam int          AW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [15:0] COL_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);

    logic [15:0]        lb_top_q [WIDTH];
    logic [15:0]        lb_mid_q [WIDTH];
    logic [AW-1:0]      addr;
    logic [15:0]        top_rd, mid_rd;

    logic [15:0]        col_q, col_d, row_q, row_d;
    logic [15:0]        crow_q, crow_d, ccol_q, ccol_d;
    logic [15:0]        win_q [9];
    logic [15:0]        win_d [9];
    logic               valid_q, valid_d, fe_q, fe_d;

    assign addr   = col_q[AW-1:0];
    assign top_rd = lb_top_q[addr];
    assign mid_rd = lb_mid_q[addr];

    // Read-before-write: the current column is read combinationally and overwritten at the edge.
    always_ff @(posedge clk) begin
        if (pixel_valid && !reset) begin
            lb_top_q[addr] <= mid_rd;
            lb_mid_q[addr] <= pixel_in;
        end
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        crow_d  = crow_q;
        ccol_d  = ccol_q;
        win_d   = win_q;
        valid_d = 1'b0;
        fe_d    = 1'b0;
        if (pixel_valid) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = top_rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = mid_rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pixel_in;
            valid_d  = (row_q >= 16'd2) && (col_q >= 16'd2);
            fe_d     = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (valid_d) begin
                crow_d = row_q - 16'd1;
                ccol_d = col_q - 16'd1;
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            crow_q  <= '0;
            ccol_q  <= '0;
            win_q   <= '{default: '0};
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            crow_q  <= crow_d;
            ccol_q  <= ccol_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
        end
    end

    assign window       = {win_q[8], win_q[7], win_q[6], win_q[5], win_q[4],
                           win_q[3], win_q[2], win_q[1], win_q[0]};
    assign window_valid = valid_q;
    assign center_row   = crow_q;
    assign center_col   = ccol_q;
    assign frame_end    = fe_q;

endmodule

// File: tb/tb_line_window_reader.sv
// Scoreboard bench for line_window_reader on a 4x4 frame: a frame-image model
// predicts each window; a monitor checks outputs after every clock edge.
module tb_line_window_reader;

    localparam int W = 4;
    localparam int H = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] pixel_in;
    logic               pixel_valid;
    logic [143:0]       window;
    logic               window_valid;
    logic [15:0]        center_row, center_col;
    logic               frame_end;

    line_window_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .window       (window),
        .window_valid (window_valid),
        .center_row   (center_row),
        .center_col   (center_col),
        .frame_end    (frame_end)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [143:0] w;
        logic [15:0]  r;
        logic [15:0]  c;
        logic         fe;
        int           seq;
    } exp_t;

    exp_t        q[$];
    logic [15:0] img [H][W];
    int          mr, mc, send_seq;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string n, input logic [143:0] a, input logic [143:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic send(input logic [15:0] pix);
        exp_t e;
        @(negedge clk);
        reset       = 1'b0;
        pixel_valid = 1'b1;
        pixel_in    = pix;
        send_seq++;
        img[mr][mc] = pix;
        if (mr >= 2 && mc >= 2) begin
            for (int k = 0; k < 9; k++)
                e.w[k*16 +: 16] = img[mr - 2 + k / 3][mc - 2 + k % 3];
            e.r   = 16'(mr - 1);
            e.c   = 16'(mc - 1);
            e.fe  = (mr == H - 1) && (mc == W - 1);
            e.seq = send_seq;
            q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        reset       = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = 16'($urandom);
    endtask

    task automatic do_reset(input logic v);
        @(negedge clk);
        reset       = 1'b1;
        pixel_valid = v;
        pixel_in    = 16'($urandom);
        mr = 0;
        mc = 0;
    endtask

    task automatic pattern_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gaps)
                    while ($urandom_range(0, 1) == 0) idle();
                send(16'(r * 16 + c));
            end
    endtask

    // Monitor: decoupled from stimulus, sampled 1 time unit after each rising edge.
    initial begin : monitor
        logic         acc, rst;
        logic [143:0] prev_w;
        logic [15:0]  prev_r, prev_c;
        int           acc_cnt;
        exp_t         e;
        acc_cnt = 0;
        prev_w  = '0;
        prev_r  = '0;
        prev_c  = '0;
        forever begin
            @(posedge clk);
            acc = pixel_valid && !reset;
            rst = reset;
            #1;
            if (rst) begin
                check("rst_window", window, '0);
                check("rst_valid", window_valid, 0);
                check("rst_row", center_row, 0);
                check("rst_col", center_col, 0);
                check("rst_frame_end", frame_end, 0);
            end else if (!acc) begin
                check("hold_window", window, prev_w);
                check("hold_row", center_row, prev_r);
                check("hold_col", center_col, prev_c);
                check("idle_valid", window_valid, 0);
                check("idle_frame_end", frame_end, 0);
            end else begin
                acc_cnt++;
                if (window_valid) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_window: got valid at row %0d col %0d expected none",
                                 center_row, center_col);
                    end else begin
                        e = q.pop_front();
                        check("win_seq", 144'(acc_cnt), 144'(e.seq));
                        check("window", window, e.w);
                        check("center_row", center_row, e.r);
                        check("center_col", center_col, e.c);
                        check("frame_end", frame_end, e.fe);
                    end
                end else begin
                    check("frame_end_no_valid", frame_end, 0);
                    if (q.size() != 0 && q[0].seq == acc_cnt) begin
                        e = q.pop_front();
                        check("missing_valid", window_valid, 1);
                    end
                end
            end
            prev_w = window;
            prev_r = center_row;
            prev_c = center_col;
        end
    end

    initial begin
        reset       = 1'b1;
        pixel_valid = 1'b0;
        pixel_in    = '0;
        mr = 0;
        mc = 0;
        send_seq = 0;
        do_reset(1'b0);
        do_reset(1'b0);

        pattern_frame(1'b0);
        idle();
        pattern_frame(1'b1);
        pattern_frame(1'b0);

        // Random data with signed extremes, random gaps.
        for (int n = 0; n < 2 * W * H; n++) begin
            logic [15:0] pix;
            case ($urandom_range(0, 4))
                0:       pix = 16'h8000;
                1:       pix = 16'h7fff;
                2:       pix = 16'hffff;
                default: pix = 16'($urandom);
            endcase
            if ($urandom_range(0, 1) == 0) idle();
            send(pix);
        end

        // Partial frame up to (2,3), then reset with a pixel presented; it must be dropped.
        while (mr != 0 || mc != 0) send(16'($urandom));
        for (int n = 0; n < 2 * W + 4; n++) send(16'(16'h0100 + n));
        do_reset(1'b1);
        pattern_frame(1'b1);
        pattern_frame(1'b0);

        repeat (3) idle();
        check("queue_drained", 144'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
